// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator controller: walks two latched operands MSB-first,
// one 2-bit digit pair per cycle, through an external combinational comparator slice.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       dig_a,
    output logic [1:0]       dig_b,
    input  logic             cmp_L,
    input  logic             cmp_E,
    input  logic             cmp_G,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             err
);

    localparam int NDIG = WIDTH / 2;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] a_sh, b_sh;

    // NOTE: the operand registers are reset too, so dig_a/dig_b are defined from the first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_LAST;
            a_q     <= '0;
            b_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a hold default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_LAST;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                unique case ({cmp_L, cmp_E, cmp_G})
                    3'b100: begin
                        lt_d    = 1'b1;
                        state_d = S_DONE;
                    end
                    3'b001: begin
                        gt_d    = 1'b1;
                        state_d = S_DONE;
                    end
                    3'b010: begin
                        // Equal digits: descend until the LSB pair, never wrapping idx.
                        if (idx_q == '0) begin
                            eq_d    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a_sh  = a_q >> {idx_q, 1'b0};
    assign b_sh  = b_q >> {idx_q, 1'b0};

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign dig_a = busy ? a_sh[1:0] : 2'b00;
    assign dig_b = busy ? b_sh[1:0] : 2'b00;
    assign lt    = lt_q;
    assign eq    = eq_q;
    assign gt    = gt_q;
    assign err   = err_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare: a WIDTH=8 instance with a stubbable slice
// model and a WIDTH=2 instance for the exhaustive digit sweep.
module tb_serial_mag_compare;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [1:0] dig_a8, dig_b8;
    logic       l8, e8, g8;
    logic       busy8, done8, lt8, eq8, gt8, err8;
    logic       stub_en = 1'b0;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic [1:0] dig_a2, dig_b2;
    logic       l2, e2, g2;
    logic       busy2, done2, lt2, eq2, gt2, err2;

    always #5 clk = ~clk;

    // Behavioural 2-bit slice; stub_en forces an all-zero (invalid) vector.
    assign l8 = stub_en ? 1'b0 : (dig_a8 <  dig_b8);
    assign e8 = stub_en ? 1'b0 : (dig_a8 == dig_b8);
    assign g8 = stub_en ? 1'b0 : (dig_a8 >  dig_b8);
    assign l2 = (dig_a2 <  dig_b2);
    assign e2 = (dig_a2 == dig_b2);
    assign g2 = (dig_a2 >  dig_b2);

    serial_mag_compare #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .dig_a(dig_a8), .dig_b(dig_b8), .cmp_L(l8), .cmp_E(e8), .cmp_G(g8),
        .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8), .err(err8)
    );

    serial_mag_compare #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .dig_a(dig_a2), .dig_b(dig_b2), .cmp_L(l2), .cmp_E(e2), .cmp_G(g2),
        .busy(busy2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2), .err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one run on u8; lat is the cycle (after the accepting edge) in which
    // done is seen, -1 if it never comes. digs collects {dig_a,dig_b} per busy cycle.
    task automatic do_run(input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [15:0] digs, output int nbusy);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 1;
        digs = '0;
        nbusy = 0;
        while (!done8 && lat < 20) begin
            if (busy8) begin
                digs = {digs[11:0], dig_a8, dig_b8};
                nbusy++;
            end
            tick();
            lat++;
        end
        if (!done8) lat = -1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy8, done8, lt8, eq8, gt8, err8, dig_a8, dig_b8} !== 10'b0) begin
            errors++;
            $display("FAIL reset_u8 got %b want 0", {busy8, done8, lt8, eq8, gt8, err8, dig_a8, dig_b8});
        end
        checks++;
        if ({busy2, done2, lt2, eq2, gt2, err2, dig_a2, dig_b2} !== 10'b0) begin
            errors++;
            $display("FAIL reset_u2 got %b want 0", {busy2, done2, lt2, eq2, gt2, err2, dig_a2, dig_b2});
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_equal();
        int lat, nb;
        logic [15:0] digs;
        do_run(8'hA5, 8'hA5, lat, digs, nb);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL eq_latency got %0d want 5", lat); end
        checks++;
        if (digs !== 16'hAA55) begin errors++; $display("FAIL eq_digits got %h want aa55", digs); end
        checks++;
        if ({lt8, eq8, gt8, err8} !== 4'b0100) begin
            errors++; $display("FAIL eq_flags got %b want 0100", {lt8, eq8, gt8, err8});
        end
        tick();
        checks++;
        if ({done8, lt8, eq8, gt8, err8, dig_a8, dig_b8} !== 9'b0_0100_0000) begin
            errors++; $display("FAIL eq_hold got %b want 001000000", {done8, lt8, eq8, gt8, err8, dig_a8, dig_b8});
        end
    endtask

    task automatic test_gt_first_digit();
        int lat, nb;
        logic [15:0] digs;
        do_run(8'h80, 8'h7F, lat, digs, nb);
        checks++;
        if (lat !== 2 || nb !== 1) begin
            errors++; $display("FAIL gt_latency got lat=%0d busy=%0d want lat=2 busy=1", lat, nb);
        end
        checks++;
        if (digs !== 16'h0009) begin errors++; $display("FAIL gt_digits got %h want 0009", digs); end
        checks++;
        if ({lt8, eq8, gt8, err8} !== 4'b0010) begin
            errors++; $display("FAIL gt_flags got %b want 0010", {lt8, eq8, gt8, err8});
        end
        tick();
    endtask

    task automatic test_lt_last_digit();
        int lat, nb;
        logic [15:0] digs;
        do_run(8'h3C, 8'h3D, lat, digs, nb);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL lt_latency got %0d want 5", lat); end
        checks++;
        if (digs !== 16'h0FF1) begin errors++; $display("FAIL lt_digits got %h want 0ff1", digs); end
        checks++;
        if ({lt8, eq8, gt8, err8} !== 4'b1000) begin
            errors++; $display("FAIL lt_flags got %b want 1000", {lt8, eq8, gt8, err8});
        end
        tick();
    endtask

    task automatic test_err();
        a8 = 8'h5A;
        b8 = 8'h5A;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        stub_en = 1'b1;
        tick();
        stub_en = 1'b0;
        checks++;
        if ({done8, busy8, lt8, eq8, gt8, err8} !== 6'b10_0001) begin
            errors++; $display("FAIL err_cycle3 got %b want 100001", {done8, busy8, lt8, eq8, gt8, err8});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        a8 = 8'hF0;
        b8 = 8'hF1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        a8 = 8'hFF;
        b8 = 8'h00;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        checks++;
        if ({done8, lt8, eq8, gt8, err8} !== 5'b1_1000) begin
            errors++; $display("FAIL ignore_start got %b want 11000", {done8, lt8, eq8, gt8, err8});
        end
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++;
        if ({busy8, done8, lt8, eq8, gt8, err8} !== 6'b10_0000) begin
            errors++; $display("FAIL b2b_restart got %b want 100000", {busy8, done8, lt8, eq8, gt8, err8});
        end
        tick();
        checks++;
        if ({done8, lt8, eq8, gt8, err8} !== 5'b1_0010) begin
            errors++; $display("FAIL b2b_result got %b want 10010", {done8, lt8, eq8, gt8, err8});
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        a8 = 8'hA5;
        b8 = 8'hA5;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, lt8, eq8, gt8, err8, dig_a8, dig_b8} !== 10'b0) begin
            errors++; $display("FAIL rst_mid_run got %b want 0", {busy8, done8, lt8, eq8, gt8, err8, dig_a8, dig_b8});
        end
        tick();
        tick();
        #2 rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done8 || busy8) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", seen_done); end
    endtask

    task automatic test_exhaustive_2bit();
        logic [3:0] want;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a2 = 2'(i);
                b2 = 2'(j);
                start2 = 1'b1;
                tick();
                start2 = 1'b0;
                tick();
                want = {i < j, i == j, i > j, 1'b0};
                checks++;
                if ({done2, lt2, eq2, gt2, err2} !== {1'b1, want}) begin
                    errors++;
                    $display("FAIL w2_%0d_%0d got %b want %b", i, j, {done2, lt2, eq2, gt2, err2}, {1'b1, want});
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_gt_first_digit();
        test_lt_last_digit();
        test_err();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_2bit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
